// File: rtl/cfg_space_arbiter_if.sv
// cfg_space_arbiter_if: bundles the two requester ports and the shared
// config-space port seen by cfg_space_arbiter.
// master = requesters plus config-space side (drives requests and read data),
// slave  = the arbiter itself.
interface cfg_space_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;

    logic              c_read;
    logic              c_write;
    logic [ADDR_W-1:0] c_address;
    logic [DATA_W-1:0] c_data_in;
    logic [DATA_W-1:0] c_data_out;

    logic              busy;
    logic              grant_id;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output c_data_out,
        input  req0_ready, req0_done, req0_rdata,
        input  req1_ready, req1_done, req1_rdata,
        input  c_read, c_write, c_address, c_data_in,
        input  busy, grant_id
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  c_data_out,
        output req0_ready, req0_done, req0_rdata,
        output req1_ready, req1_done, req1_rdata,
        output c_read, c_write, c_address, c_data_in,
        output busy, grant_id
    );
endinterface

// File: rtl/cfg_space_arbiter.sv
// cfg_space_arbiter: shares one config-space port between the sideband
// register handler (req0) and the lane-training FSM (req1). One access is
// issued per grant; reads wait RD_LAT cycles before data returns.
// Build option: define CFG_ARB_FIXED_PRIO_EN for strict priority (req0 wins
// ties); otherwise ties are resolved round-robin.
module cfg_space_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic                local_clk,
    input logic                rst,
    cfg_space_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic              last_grant;
    logic              cur_write;
    logic [3:0]        lat_cnt;
    logic              winner;
    logic              accept;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Choose the requester to serve and mux its request fields; accept is
    // gated by rst so ready is low while reset is held.
    always_comb begin
        winner = 1'b0;
`ifdef CFG_ARB_FIXED_PRIO_EN
        winner = ~bus.req0_valid;
`else
        if (bus.req0_valid && bus.req1_valid)
            winner = ~last_grant;
        else
            winner = ~bus.req0_valid;
`endif
        accept    = rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_write = winner ? bus.req1_write : bus.req0_write;
        sel_addr  = winner ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = winner ? bus.req1_wdata : bus.req0_wdata;
    end

    assign bus.req0_ready = accept & ~winner;
    assign bus.req1_ready = accept &  winner;
    assign bus.busy       = (state != IDLE);

    // Access sequencer: latch on accept, strobe once in ISSUE, count out the
    // read latency in WAIT, pulse done to the granted requester in DONE.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            cur_write      <= 1'b0;
            lat_cnt        <= '0;
            bus.c_read     <= 1'b0;
            bus.c_write    <= 1'b0;
            bus.c_address  <= '0;
            bus.c_data_in  <= '0;
            bus.grant_id   <= 1'b0;
            bus.req0_done  <= 1'b0;
            bus.req1_done  <= 1'b0;
            bus.req0_rdata <= '0;
            bus.req1_rdata <= '0;
        end else begin
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_write     <= sel_write;
                        bus.c_write   <= sel_write;
                        bus.c_read    <= ~sel_write;
                        bus.c_address <= sel_addr;
                        bus.c_data_in <= sel_wdata;
                        bus.grant_id  <= winner;
                        last_grant    <= winner;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.c_read  <= 1'b0;
                    bus.c_write <= 1'b0;
                    lat_cnt     <= '0;
                    if (cur_write) begin
                        state <= DONE;
                        if (bus.grant_id) bus.req1_done <= 1'b1;
                        else              bus.req0_done <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        state   <= DONE;
                        if (bus.grant_id) begin
                            bus.req1_rdata <= bus.c_data_out;
                            bus.req1_done  <= 1'b1;
                        end else begin
                            bus.req0_rdata <= bus.c_data_out;
                            bus.req0_done  <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_space_arbiter.sv
// tb_cfg_space_arbiter: directed table-driven bench for cfg_space_arbiter
// with a small config-space model (RD_LAT-deep read pipeline).
module tb_cfg_space_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    int overlap_cnt = 0;
    int strobe_cnt  = 0;
    int done0_cnt   = 0;
    int done1_cnt   = 0;
    int ready1_cnt  = 0;

    int grant_log[$];

    cfg_space_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    cfg_space_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .local_clk (clk),
        .rst       (rst),
        .bus       (bus_if)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Config-space model: writes land on the strobe edge, reads appear
    // exactly RD_LAT cycles after the c_read cycle and are garbage otherwise.
    logic              model_clear;
    logic [DATA_W-1:0] mem     [256];
    logic              written [256];
    logic [DATA_W-1:0] pipe_d  [RD_LAT];
    logic              pipe_v  [RD_LAT];

    function automatic logic [31:0] default_word(input logic [7:0] a);
        case (a)
            8'h22:   return 32'h12345678;
            8'h00:   return 32'hA5A5A5A5;
            default: return {24'h5A0000, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (model_clear) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_d[k] <= '0;
            end
        end else begin
            if (bus_if.c_write) begin
                mem[bus_if.c_address]     <= bus_if.c_data_in;
                written[bus_if.c_address] <= 1'b1;
            end
            pipe_v[0] <= bus_if.c_read;
            pipe_d[0] <= written[bus_if.c_address] ? mem[bus_if.c_address]
                                                   : default_word(bus_if.c_address);
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    assign bus_if.c_data_out = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0BAD0;

    // Event monitor sampled mid-cycle, after inputs have settled.
    always begin
        @(negedge clk);
        #3;
        if (bus_if.c_read && bus_if.c_write) overlap_cnt++;
        if (bus_if.c_read || bus_if.c_write) strobe_cnt++;
        if (bus_if.req0_done) done0_cnt++;
        if (bus_if.req1_done) done1_cnt++;
        if (bus_if.req1_ready) ready1_cnt++;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int          n;
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_r0;
        logic [31:0] exp_r1;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic w,
                           input logic [7:0] a, input logic [31:0] d);
        if (n == 0) begin
            bus_if.req0_valid = v; bus_if.req0_write = w;
            bus_if.req0_addr  = a; bus_if.req0_wdata = d;
        end else begin
            bus_if.req1_valid = v; bus_if.req1_write = w;
            bus_if.req1_addr  = a; bus_if.req1_wdata = d;
        end
    endtask

    function automatic logic get_ready(input int n);
        return (n == 0) ? bus_if.req0_ready : bus_if.req1_ready;
    endfunction

    function automatic logic get_done(input int n);
        return (n == 0) ? bus_if.req0_done : bus_if.req1_done;
    endfunction

    // One uncontended access with cycle-exact checks of strobes and done.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        set_req(v.n, 1'b1, v.write, v.addr, v.wdata);
        #1;
        check_output("ready_own", get_ready(v.n), 1'b1);
        check_output("ready_other", get_ready(1 - v.n), 1'b0);
        @(negedge clk);
        set_req(v.n, 1'b0, v.write, v.addr, v.wdata);
        #1;
        check_output("issue_c_write", bus_if.c_write, v.write);
        check_output("issue_c_read", bus_if.c_read, !v.write);
        check_output("issue_c_address", bus_if.c_address, v.addr);
        if (v.write) check_output("issue_c_data_in", bus_if.c_data_in, v.wdata);
        check_output("issue_grant_id", bus_if.grant_id, v.n);
        check_output("issue_done_own", get_done(v.n), 1'b0);
        if (!v.write) begin
            for (int k = 0; k < RD_LAT; k++) begin
                @(negedge clk);
                #1;
                check_output("wait_strobes", bus_if.c_read | bus_if.c_write, 1'b0);
                check_output("wait_done_own", get_done(v.n), 1'b0);
            end
        end
        @(negedge clk);
        #1;
        check_output("done_own", get_done(v.n), 1'b1);
        check_output("done_other", get_done(1 - v.n), 1'b0);
        check_output("req0_rdata", bus_if.req0_rdata, v.exp_r0);
        check_output("req1_rdata", bus_if.req1_rdata, v.exp_r1);
        @(negedge clk);
        #1;
        check_output("after_done_own", get_done(v.n), 1'b0);
        check_output("after_busy", bus_if.busy, 1'b0);
        check_output("hold_c_address", bus_if.c_address, v.addr);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (!bus_if.busy) break;
        end
        check_output("idle_timeout", bus_if.busy, 1'b0);
    endtask

    // Assert reset for a few cycles, check every output is zero, release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        check_output("rst_c_read", bus_if.c_read, 1'b0);
        check_output("rst_c_write", bus_if.c_write, 1'b0);
        check_output("rst_c_address", bus_if.c_address, 8'h00);
        check_output("rst_c_data_in", bus_if.c_data_in, 32'h0);
        check_output("rst_ready0", bus_if.req0_ready, 1'b0);
        check_output("rst_ready1", bus_if.req1_ready, 1'b0);
        check_output("rst_done0", bus_if.req0_done, 1'b0);
        check_output("rst_done1", bus_if.req1_done, 1'b0);
        check_output("rst_rdata0", bus_if.req0_rdata, 32'h0);
        check_output("rst_rdata1", bus_if.req1_rdata, 32'h0);
        check_output("rst_busy", bus_if.busy, 1'b0);
        check_output("rst_grant_id", bus_if.grant_id, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Keep both requesters asking for reads until each has been accepted the
    // requested number of times; valid is re-raised right after an accept.
    task automatic serve(input int want0, input int want1,
                         input logic [7:0] a0, input logic [7:0] a1);
        int left0;
        int left1;
        int cyc;
        left0 = want0;
        left1 = want1;
        cyc   = 0;
        grant_log.delete();
        @(negedge clk);
        set_req(0, left0 > 0, 1'b0, a0, 32'h0);
        set_req(1, left1 > 0, 1'b0, a1, 32'h0);
        while ((left0 > 0 || left1 > 0) && cyc < 400) begin
            #1;
            if (bus_if.req0_ready) begin grant_log.push_back(0); left0--; end
            if (bus_if.req1_ready) begin grant_log.push_back(1); left1--; end
            @(negedge clk);
            cyc++;
            set_req(0, left0 > 0, 1'b0, a0, 32'h0);
            set_req(1, left1 > 0, 1'b0, a1, 32'h0);
        end
        check_output("serve_pending", left0 + left1, 0);
        wait_idle(50);
    endtask

    task automatic check_order(input string name, input int exp_order[$]);
        check_output({name, "_len"}, grant_log.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
            check_output(name, grant_log[i], exp_order[i]);
    endtask

    initial begin
        int s0;
        int d0;
        int d1;
        int r1;

        vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1, 1'b0, 8'h22, 32'h0,        32'h0,        32'h12345678};
        vecs[2] = '{1, 1'b1, 8'h22, 32'hCAFEF00D, 32'h0,        32'h12345678};
        vecs[3] = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 32'h12345678};
        vecs[4] = '{1, 1'b0, 8'h22, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
        vecs[5] = '{0, 1'b1, 8'hFF, 32'h00000001, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[6] = '{0, 1'b0, 8'hFF, 32'h0,        32'h00000001, 32'hCAFEF00D};
        vecs[7] = '{1, 1'b0, 8'h00, 32'h0,        32'h00000001, 32'hA5A5A5A5};

        model_clear = 1'b1;
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(negedge clk);
        model_clear = 1'b0;
        do_reset();

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

        // Tie straight after reset: req0 goes first in both builds.
        do_reset();
        serve(1, 1, 8'h10, 8'h22);
        check_order("tie1_order", '{0, 1});
        check_output("tie1_rdata0", bus_if.req0_rdata, 32'hDEADBEEF);
        check_output("tie1_rdata1", bus_if.req1_rdata, 32'hCAFEF00D);

        // req0 becomes last grant, so the next tie favours req1 in round-robin.
        apply_stimulus('{0, 1'b1, 8'h40, 32'h11112222, 32'hDEADBEEF, 32'hCAFEF00D});
        serve(1, 1, 8'h40, 8'h10);
`ifdef CFG_ARB_FIXED_PRIO_EN
        check_order("tie2_order", '{0, 1});
`else
        check_order("tie2_order", '{1, 0});
`endif
        check_output("tie2_rdata0", bus_if.req0_rdata, 32'h11112222);
        check_output("tie2_rdata1", bus_if.req1_rdata, 32'hDEADBEEF);

        // req1 is last grant; req0 then stays valid continuously.
        apply_stimulus('{1, 1'b1, 8'h50, 32'h33334444, 32'h11112222, 32'hDEADBEEF});
        serve(2, 2, 8'hFF, 8'h22);
`ifdef CFG_ARB_FIXED_PRIO_EN
        check_order("starve_order", '{0, 0, 1, 1});
`else
        check_order("starve_order", '{0, 1, 0, 1});
`endif
        check_output("starve_rdata0", bus_if.req0_rdata, 32'h00000001);
        check_output("starve_rdata1", bus_if.req1_rdata, 32'hCAFEF00D);

        // req1 pulses valid for one cycle while req0's read is in flight.
        s0 = strobe_cnt; d0 = done0_cnt; d1 = done1_cnt; r1 = ready1_cnt;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 8'h50, 32'h0);
        #1;
        check_output("wd_ready0", bus_if.req0_ready, 1'b1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h50, 32'h0);
        set_req(1, 1'b1, 1'b1, 8'h60, 32'h99999999);
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 8'h60, 32'h99999999);
        wait_idle(50);
        repeat (4) @(negedge clk);
        #4;
        check_output("wd_strobes", strobe_cnt - s0, 1);
        check_output("wd_done0", done0_cnt - d0, 1);
        check_output("wd_done1", done1_cnt - d1, 0);
        check_output("wd_ready1", ready1_cnt - r1, 0);
        check_output("wd_rdata0", bus_if.req0_rdata, 32'h33334444);

        // Reset during WAIT of a req1 read: everything drops, no done pulse.
        d1 = done1_cnt;
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 8'h22, 32'h0);
        #1;
        check_output("mid_ready1", bus_if.req1_ready, 1'b1);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 8'h22, 32'h0);
        @(negedge clk);
        #1;
        check_output("mid_in_wait_busy", bus_if.busy, 1'b1);
        rst = 1'b0;
        #1;
        check_output("mid_c_read", bus_if.c_read, 1'b0);
        check_output("mid_c_write", bus_if.c_write, 1'b0);
        check_output("mid_c_address", bus_if.c_address, 8'h00);
        check_output("mid_busy", bus_if.busy, 1'b0);
        check_output("mid_grant_id", bus_if.grant_id, 1'b0);
        check_output("mid_rdata1", bus_if.req1_rdata, 32'h0);
        repeat (RD_LAT + 3) @(negedge clk);
        #4;
        check_output("mid_no_done1", done1_cnt - d1, 0);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus('{0, 1'b1, 8'h33, 32'h55AA55AA, 32'h0, 32'h0});

        check_output("strobe_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
